if_stage: RTL and testbench

- Instruction-fetch stage of the MyProc2 pipeline.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Delivers IR_out/PC_out to the decode stage and honours the same IsStall/IsFlush controls as decode.
- Accepts branch/jump redirects from execute and stops fetching on HALT.

---
 rtl/if_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_if_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the MyProc2 pipeline.
//
// Owns the word-addressed program counter and fetches one instruction word
// at a time from instruction memory over a req/ack handshake. Fetched words
// are presented to decode on IR_out/PC_out, with support for stall (hold
// outputs, with a one-entry hold buffer for a word that arrives during a
// stall), flush (squash the presented instruction), branch/jump redirects
// from execute, and stopping on a HALT instruction.
//
// Ports:
//   clk         in   1        clock, all state on rising edge
//   rst         in   1        asynchronous, active-high reset
//   imem_req    out  1        fetch request, held until accepted
//   imem_addr   out  WIDTH-2  word address of the request
//   imem_rdata  in   WIDTH    instruction word, valid with imem_ack
//   imem_ack    in   1        transfer completes when imem_req & imem_ack
//   Br_taken    in   1        redirect pulse from execute
//   Br_target   in   WIDTH-2  redirect word address
//   IsStall     in   1        decode cannot accept; hold outputs
//   IsFlush     in   1        squash instruction presented to decode
//   IR_out      out  WIDTH    instruction to decode
//   PC_out      out  WIDTH-2  word address of IR_out
//   Halted      out  1        HALT delivered; fetch stopped
//   fetch_cnt   out  32       (IF_PERF_CNT_EN only) non-killed transfers
//   stall_cnt   out  32       (IF_PERF_CNT_EN only) stalled REQ/HOLD edges
//
// Optional feature macro: IF_PERF_CNT_EN adds the saturating performance
// counters fetch_cnt and stall_cnt. Without it, those ports do not exist.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-3:0]   RESET_PC = {(WIDTH-2){1'b0}},
    parameter logic [5:0]         HALT_OPC = 6'b111111
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [WIDTH-3:0]   imem_addr,
    input  logic [WIDTH-1:0]   imem_rdata,
    input  logic               imem_ack,
    input  logic               Br_taken,
    input  logic [WIDTH-3:0]   Br_target,
    input  logic               IsStall,
    input  logic               IsFlush,
    output logic [WIDTH-1:0]   IR_out,
    output logic [WIDTH-3:0]   PC_out,
    output logic               Halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] NOP     = {WIDTH{1'b0}};
    localparam logic [WIDTH-3:0] PC_ZERO = {(WIDTH-2){1'b0}};
    localparam logic [WIDTH-3:0] PC_ONE  = {{(WIDTH-3){1'b0}}, 1'b1};

    // Registered state
    state_t             state_r;
    logic [WIDTH-3:0]   pc_r;
    logic               kill_r;
    logic [WIDTH-3:0]   kill_addr_r;
    logic [WIDTH-1:0]   hold_ir_r;
    logic [WIDTH-3:0]   hold_pc_r;
    logic [WIDTH-1:0]   ir_r;
    logic [WIDTH-3:0]   pc_out_r;
    logic               halted_r;

    // Next-state values
    state_t             state_s;
    logic [WIDTH-3:0]   pc_s;
    logic               kill_s;
    logic [WIDTH-3:0]   kill_addr_s;
    logic [WIDTH-1:0]   hold_ir_s;
    logic [WIDTH-3:0]   hold_pc_s;
    logic [WIDTH-1:0]   ir_s;
    logic [WIDTH-3:0]   pc_out_s;
    logic               halted_s;

    logic               xfer_s;
    logic               rdata_halt_s;
    logic               hold_halt_s;

    // Opcode is the top six bits of the instruction word.
    function automatic logic is_halt(input logic [WIDTH-1:0] word);
        return (word[WIDTH-1 -: 6] == HALT_OPC);
    endfunction

    assign xfer_s       = (state_r == REQ) && imem_ack;
    assign rdata_halt_s = is_halt(imem_rdata);
    assign hold_halt_s  = is_halt(hold_ir_r);

    // State and datapath register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            kill_r      <= 1'b0;
            kill_addr_r <= PC_ZERO;
            hold_ir_r   <= NOP;
            hold_pc_r   <= PC_ZERO;
            ir_r        <= NOP;
            pc_out_r    <= PC_ZERO;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            kill_r      <= kill_s;
            kill_addr_r <= kill_addr_s;
            hold_ir_r   <= hold_ir_s;
            hold_pc_r   <= hold_pc_s;
            ir_r        <= ir_s;
            pc_out_r    <= pc_out_s;
            halted_r    <= halted_s;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        kill_s      = kill_r;
        kill_addr_s = kill_addr_r;
        hold_ir_s   = hold_ir_r;
        hold_pc_s   = hold_pc_r;
        ir_s        = ir_r;
        pc_out_s    = pc_out_r;
        halted_s    = halted_r;

        if (Br_taken) begin
            pc_s      = Br_target;
            ir_s      = NOP;
            pc_out_s  = PC_ZERO;
            hold_ir_s = NOP;
            hold_pc_s = PC_ZERO;
            halted_s  = 1'b0;
            state_s   = REQ;
            // A request still waiting for ack must stay stable on the bus;
            // remember its address and discard its word when it arrives.
            if ((state_r == REQ) && !imem_ack) begin
                kill_s = 1'b1;
                if (!kill_r) begin
                    kill_addr_s = pc_r;
                end else begin
                    kill_addr_s = kill_addr_r;
                end
            end else begin
                kill_s = 1'b0;
            end
        end else if (xfer_s && kill_r) begin
            // Word belongs to the pre-redirect stream: drop it.
            kill_s = 1'b0;
            if (IsFlush && !IsStall) begin
                ir_s     = NOP;
                pc_out_s = PC_ZERO;
            end else begin
                ir_s = ir_r;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = REQ;
                end
                REQ: begin
                    if (xfer_s) begin
                        if (IsStall) begin
                            hold_ir_s = imem_rdata;
                            hold_pc_s = pc_r;
                            state_s   = HOLD;
                            if (!rdata_halt_s) begin
                                pc_s = pc_r + PC_ONE;
                            end else begin
                                pc_s = pc_r;
                            end
                        end else begin
                            // A new word replaces whatever decode held, so a
                            // coincident flush is already satisfied.
                            ir_s     = imem_rdata;
                            pc_out_s = pc_r;
                            if (rdata_halt_s) begin
                                state_s  = HALTED;
                                halted_s = 1'b1;
                            end else begin
                                pc_s = pc_r + PC_ONE;
                            end
                        end
                    end else if (IsFlush && !IsStall) begin
                        ir_s     = NOP;
                        pc_out_s = PC_ZERO;
                    end else begin
                        ir_s = ir_r;
                    end
                end
                HOLD: begin
                    if (!IsStall) begin
                        ir_s     = hold_ir_r;
                        pc_out_s = hold_pc_r;
                        if (hold_halt_s) begin
                            state_s  = HALTED;
                            halted_s = 1'b1;
                        end else begin
                            state_s = REQ;
                        end
                    end else begin
                        state_s = HOLD;
                    end
                end
                HALTED: begin
                    if (IsFlush && !IsStall) begin
                        ir_s     = NOP;
                        pc_out_s = PC_ZERO;
                    end else begin
                        ir_s = ir_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Memory request outputs, decoded from registered state
    always_comb begin
        imem_req  = (state_r == REQ);
        if (kill_r) begin
            imem_addr = kill_addr_r;
        end else begin
            imem_addr = pc_r;
        end
    end

    assign IR_out = ir_r;
    assign PC_out = pc_out_r;
    assign Halted = halted_r;

`ifdef IF_PERF_CNT_EN
    // Saturating fetch and stall counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 32'h0000_0000;
            stall_cnt <= 32'h0000_0000;
        end else begin
            if (xfer_s && !kill_r && (fetch_cnt != 32'hFFFF_FFFF)) begin
                fetch_cnt <= fetch_cnt + 32'h0000_0001;
            end
            if (IsStall && ((state_r == REQ) || (state_r == HOLD)) &&
                (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'h0000_0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : directed self-checking bench for if_stage.
// A small instruction memory (mem[i] = 0x1000_0000 | i) feeds imem_rdata
// combinationally from imem_addr; imem_ack is driven by the directed steps.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic         clk;
    logic         rst;
    logic         imem_req;
    logic [29:0]  imem_addr;
    logic [31:0]  imem_rdata;
    logic         imem_ack;
    logic         Br_taken;
    logic [29:0]  Br_target;
    logic         IsStall;
    logic         IsFlush;
    logic [31:0]  IR_out;
    logic [29:0]  PC_out;
    logic         Halted;
`ifdef IF_PERF_CNT_EN
    logic [31:0]  fetch_cnt;
    logic [31:0]  stall_cnt;
`endif

    logic [31:0]  mem [0:127];
    int           n_cmp;
    int           n_err;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .Br_taken   (Br_taken),
        .Br_target  (Br_target),
        .IsStall    (IsStall),
        .IsFlush    (IsFlush),
        .IR_out     (IR_out),
        .PC_out     (PC_out),
        .Halted     (Halted)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    assign imem_rdata = mem[imem_addr[6:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | i;
        rst       = 1'b1;
        imem_ack  = 1'b0;
        Br_taken  = 1'b0;
        Br_target = 30'd0;
        IsStall   = 1'b0;
        IsFlush   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ir",     IR_out,             32'h0000_0000);
        chk("rst_pc",     {2'b00, PC_out},    32'h0000_0000);
        chk("rst_req",    {31'd0, imem_req},  32'h0000_0000);
        chk("rst_halted", {31'd0, Halted},    32'h0000_0000);

        // Zero-wait memory: A,B,C,D on consecutive edges
        imem_ack = 1'b1;
        rst = 1'b0;
        step();
        chk("zw_req",  {31'd0, imem_req},     32'h0000_0001);
        chk("zw_addr", {2'b00, imem_addr},    32'h0000_0000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("zw_ir", IR_out,              32'h1000_0000 | i);
            chk("zw_pc", {2'b00, PC_out},     i);
        end

        // Ack three cycles after request
        imem_ack = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("w3_req",  {31'd0, imem_req},  32'h0000_0001);
            chk("w3_addr", {2'b00, imem_addr}, 32'h0000_0000);
        end
        imem_ack = 1'b1;
        step();
        chk("w3_ir",    IR_out,                32'h1000_0000);
        chk("w3_pc",    {2'b00, PC_out},       32'h0000_0000);
        chk("w3_next",  {2'b00, imem_addr},    32'h0000_0001);

        // Stall for 4 cycles while B is acked (ack left high: ignored in HOLD)
        IsStall = 1'b1;
        step();
        chk("st_req",   {31'd0, imem_req},     32'h0000_0000);
        chk("st_ir",    IR_out,                32'h1000_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_hold_ir", IR_out,          32'h1000_0000);
            chk("st_hold_pc", {2'b00, PC_out}, 32'h0000_0000);
        end
        IsStall = 1'b0;
        step();
        chk("st_b_ir",  IR_out,                32'h1000_0001);
        chk("st_b_pc",  {2'b00, PC_out},       32'h0000_0001);
        chk("st_addr",  {2'b00, imem_addr},    32'h0000_0002);
        step();
        chk("st_c_ir",  IR_out,                32'h1000_0002);
        chk("st_c_pc",  {2'b00, PC_out},       32'h0000_0002);

        // Redirect while request at addr 5 is outstanding
        step();
        step();
        imem_ack = 1'b0;
        chk("br_pre_ir",   IR_out,             32'h1000_0004);
        chk("br_pre_addr", {2'b00, imem_addr}, 32'h0000_0005);
        step();
        Br_taken  = 1'b1;
        Br_target = 30'h40;
        step();
        Br_taken  = 1'b0;
        chk("br_nop",    IR_out,               32'h0000_0000);
        chk("br_pc0",    {2'b00, PC_out},      32'h0000_0000);
        chk("br_hold_a", {2'b00, imem_addr},   32'h0000_0005);
        chk("br_hold_r", {31'd0, imem_req},    32'h0000_0001);
        imem_ack = 1'b1;
        step();
        chk("br_drop_ir", IR_out,              32'h0000_0000);
        chk("br_tgt",     {2'b00, imem_addr},  32'h0000_0040);
        step();
        chk("br_new_ir",  IR_out,              32'h1000_0040);
        chk("br_new_pc",  {2'b00, PC_out},     32'h0000_0040);

        // HALT at addr 2, then resume with a redirect to 0
        mem[2] = 32'hFC00_0002;
        do_reset();
        step();
        step();
        step();
        step();
        chk("h_ir",     IR_out,                32'hFC00_0002);
        chk("h_pc",     {2'b00, PC_out},       32'h0000_0002);
        chk("h_halted", {31'd0, Halted},       32'h0000_0001);
        for (int i = 0; i < 10; i++) begin
            chk("h_noreq", {31'd0, imem_req},  32'h0000_0000);
            step();
        end
        Br_taken  = 1'b1;
        Br_target = 30'h0;
        step();
        Br_taken  = 1'b0;
        chk("h_clr",    {31'd0, Halted},       32'h0000_0000);
        chk("h_req",    {31'd0, imem_req},     32'h0000_0001);
        chk("h_addr",   {2'b00, imem_addr},    32'h0000_0000);
        step();
        chk("h_res_ir", IR_out,                32'h1000_0000);

        // Stall beats flush, then flush alone squashes to NOP
        imem_ack = 1'b0;
        IsStall  = 1'b1;
        IsFlush  = 1'b1;
        step();
        chk("sf_ir",    IR_out,                32'h1000_0000);
        IsStall = 1'b0;
        step();
        IsFlush = 1'b0;
        chk("fl_ir",    IR_out,                32'h0000_0000);
        chk("fl_pc",    {2'b00, PC_out},       32'h0000_0000);
        chk("fl_addr",  {2'b00, imem_addr},    32'h0000_0001);
        mem[2] = 32'h1000_0002;

        // Async reset during outstanding request at addr 7
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 8; i++) step();
        imem_ack = 1'b0;
        step();
        chk("ar_addr",  {2'b00, imem_addr},    32'h0000_0007);
        chk("ar_ir",    IR_out,                32'h1000_0006);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_rst_ir",  IR_out,              32'h0000_0000);
        chk("ar_rst_pc",  {2'b00, PC_out},     32'h0000_0000);
        chk("ar_rst_req", {31'd0, imem_req},   32'h0000_0000);
`ifdef IF_PERF_CNT_EN
        chk("ar_fcnt",    fetch_cnt,           32'h0000_0000);
        chk("ar_scnt",    stall_cnt,           32'h0000_0000);
`endif
        step();
        rst = 1'b0;
        step();
        chk("ar_req",   {31'd0, imem_req},     32'h0000_0001);
        chk("ar_first", {2'b00, imem_addr},    32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
